bcd_counter_scanner: RTL and testbench
======================================

Name: bcd_counter_scanner

Overview:
- Multi-digit BCD up/down event counter with a time-multiplexed digit scanner.
- Sits directly upstream of the 7-segment decoders and feeds one 4-bit BCD digit per scan slot to their 4-bit input.
- Provides active-low digit-select lines for a common-anode display, plus a leading-zero blank flag.
- Packs the full count for host readback.

Parameters:
- NUM_DIGITS, 4, number of BCD digits. Legal range 1..8. Digit 0 is least significant.
- SCAN_DIV, 1000, clock cycles each digit stays selected. Must be ≥1. Prescaler width is $clog2(SCAN_DIV+1).

Ports:
- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous active-low reset
- inc  in  1  count-up request, sampled each clock
- dec  in  1  count-down request, sampled each clock
- clr  in  1  synchronous clear of count
- count  out  4*NUM_DIGITS  packed BCD count; digit i is at [4i+3:4i]
- carry  out  1  one-cycle pulse on up-wrap
- borrow  out  1  one-cycle pulse on down-wrap
- bcd  out  4  BCD value of the currently scanned digit, to decoder input
- digit_sel  out  NUM_DIGITS  one-hot active-low; bit i low selects digit i
- blank  out  1  high when the currently scanned digit is a leading zero

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, carry=0, borrow=0
  - prescaler=0, scan index=0
  - therefore digit_sel = all ones except bit0=0, bcd=0, blank=0
- Release: synchronous to clk; first count or scan update occurs on the first rising edge with rst_n high.
- Count update priority, evaluated each rising edge:
  1. clr=1: count←0; carry and borrow are 0 next cycle. inc/dec are ignored.
  2. inc=1 and dec=1: count holds; no pulse.
  3. inc=1: BCD increment with ripple. A digit at 9 becomes 0 and increments the next digit. All digits at 9 wrap to all-0 and carry=1 for exactly the following cycle.
  4. dec=1: BCD decrement with ripple. A digit at 0 becomes 9 and decrements the next digit. All digits at 0 wrap to all-9 and borrow=1 for exactly the following cycle.
  5. Otherwise: count holds.
- Counting latency: 1 cycle from sampled request to updated count.
- Holding inc high counts once per cycle.
- Every digit of count is always a valid BCD value (0–9); values A–F never appear.
- carry and borrow are registered and deassert the cycle after they assert, unless another wrap occurs.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1 every cycle, independent of inc/dec/clr.
  - At terminal count the prescaler returns to 0 and scan index advances idx←(idx+1) mod NUM_DIGITS.
  - With SCAN_DIV=1, the index advances every cycle.
  - Each digit is selected for exactly SCAN_DIV cycles. Sequence is 0,1,…,NUM_DIGITS-1,0,…
- Outputs derived from registered state:
  - bcd, digit_sel and blank are pure functions of registered count and scan index, so they are glitch-free at clock granularity.
  - A count change shows on bcd in the same cycle it shows on count.
  - digit_sel has exactly one bit low at all times after reset.
- Blanking:
  - For idx>0, blank=1 iff digits idx..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so 0 displays as a single "0".
  - bcd still presents the digit value (0) while blanked; downstream gates the segments.
- Reset mid-scan or mid-count: immediate return to reset values, with no pending pulse retained.

Test Plan:
1. Reset: hold rst_n=0 with inc=1 for 5 cycles, then release → count=0000, carry=0, digit_sel=1110, bcd=0, blank=0 during reset.
2. Ripple increment: preload to 0099 via 99 inc pulses, then one inc → count=0100 one cycle later; no carry.
3. Wrap up: count=9999, inc=1 one cycle → count=0000 and carry=1 for exactly one cycle.
4. Wrap down: from 0000, dec=1 one cycle → count=9999 and borrow=1 for one cycle.
5. Priority: at 0042, inc=dec=1 → holds 0042. Then clr=inc=1 → 0000 with no carry.
6. Scan and blanking at SCAN_DIV=4, count=0042:
   - digit_sel steps 1110→1101→1011→0111→1110, each lasting 4 cycles.
   - bcd sequence is 2,4,0,0.
   - blank sequence is 0,0,1,1.
   - Asserting rst_n low mid-slot forces digit_sel to 1110 immediately.

Source files
------------

// File: rtl/bcd_counter_scanner.sv
// Multi-digit BCD up/down event counter with a time-multiplexed digit scanner
// for a common-anode 7-segment display. The per-digit ripple step is its own module.

module bcd_counter_scanner_digit (
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] up,
  output logic [3:0] dn,
  output logic       co,
  output logic       bo
);
  // ci/bi mean "every lower digit wrapped", so this digit must step.
  assign co = ci && (d == 4'd9);
  assign bo = bi && (d == 4'd0);
  assign up = !ci ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
  assign dn = !bi ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
endmodule

module bcd_counter_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry,
  output logic                    borrow,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0][3:0] cnt, cnt_up, cnt_dn;
  logic [NUM_DIGITS:0]        ci, bi;
  logic [PW-1:0]              presc;
  logic [IW-1:0]              idx;
  logic                       z;

  assign ci[0] = 1'b1;
  assign bi[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_counter_scanner_digit u_dig (
      .d  (cnt[g]),
      .ci (ci[g]),
      .bi (bi[g]),
      .up (cnt_up[g]),
      .dn (cnt_dn[g]),
      .co (ci[g+1]),
      .bo (bi[g+1])
    );
  end

  // Top of the ripple chain is the full-width wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      carry  <= 1'b0;
      borrow <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt   <= cnt_up;
        carry <= ci[NUM_DIGITS];
      end else if (dec && !inc) begin
        cnt    <= cnt_dn;
        borrow <= bi[NUM_DIGITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign count = cnt;

  // Walk from the top digit down so z means "this digit and all above are zero".
  always_comb begin
    bcd       = 4'd0;
    digit_sel = '1;
    blank     = 1'b0;
    z         = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && (cnt[i] == 4'd0);
      if (idx == IW'(i)) begin
        bcd          = cnt[i];
        digit_sel[i] = 1'b0;
        blank        = (i != 0) && z;
      end
    end
  end
endmodule

// File: tb/tb_bcd_counter_scanner.sv
// Directed bench for bcd_counter_scanner at NUM_DIGITS=4, SCAN_DIV=4.

module tb_bcd_counter_scanner;
  logic        clk = 1'b0;
  logic        rst_n, inc, dec, clr;
  logic [15:0] count;
  logic        carry, borrow, blank;
  logic [3:0]  bcd;
  logic [3:0]  digit_sel;

  int errs   = 0;
  int checks = 0;
  int k      = 0;

  logic [3:0] exp_sel   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] exp_bcd   [4] = '{4'd2, 4'd4, 4'd0, 4'd0};
  logic       exp_blank [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  bcd_counter_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (inc),
    .dec       (dec),
    .clr       (clr),
    .count     (count),
    .carry     (carry),
    .borrow    (borrow),
    .bcd       (bcd),
    .digit_sel (digit_sel),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  // k = rising edges since reset release; scan slot = (k/4)%4.
  task automatic tick();
    @(posedge clk);
    if (rst_n) k++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; inc = 1'b1; dec = 1'b0; clr = 1'b0;
    repeat (5) tick();
    chk("rst_count", count, 32'h0000);
    chk("rst_carry", carry, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_sel", digit_sel, 32'b1110);
    chk("rst_bcd", bcd, 0);
    chk("rst_blank", blank, 0);

    inc = 1'b0; rst_n = 1'b1; k = 0;
    tick();
    chk("idle_hold", count, 32'h0000);

    inc = 1'b1;
    repeat (99) tick();
    chk("preload_99", count, 32'h0099);
    tick();
    chk("ripple_100", count, 32'h0100);
    chk("ripple_nocarry", carry, 0);

    inc = 1'b0; dec = 1'b1;
    repeat (100) tick();
    chk("down_to_0", count, 32'h0000);
    chk("down_noborrow", borrow, 0);
    tick();
    chk("wrap_dn_count", count, 32'h9999);
    chk("wrap_dn_borrow", borrow, 1);
    dec = 1'b0;
    tick();
    chk("borrow_1cyc", borrow, 0);
    chk("hold_9999", count, 32'h9999);

    inc = 1'b1;
    tick();
    chk("wrap_up_count", count, 32'h0000);
    chk("wrap_up_carry", carry, 1);
    inc = 1'b0;
    tick();
    chk("carry_1cyc", carry, 0);

    inc = 1'b1;
    repeat (42) tick();
    chk("preload_42", count, 32'h0042);
    dec = 1'b1;
    tick();
    chk("incdec_hold", count, 32'h0042);
    chk("incdec_nocarry", carry, 0);
    chk("incdec_noborrow", borrow, 0);
    dec = 1'b0; clr = 1'b1;
    tick();
    chk("clr_count", count, 32'h0000);
    chk("clr_nocarry", carry, 0);
    clr = 1'b0;
    repeat (42) tick();
    inc = 1'b0;
    tick();
    chk("scan_preload", count, 32'h0042);

    for (int n = 0; n < 16; n++) begin
      int s;
      s = (k / 4) % 4;
      chk($sformatf("scan_sel_k%0d", k), digit_sel, exp_sel[s]);
      chk($sformatf("scan_bcd_k%0d", k), bcd, exp_bcd[s]);
      chk($sformatf("scan_blank_k%0d", k), blank, exp_blank[s]);
      tick();
    end

    // Mid-slot reset: park in slot 2, second cycle, then drop rst_n away from an edge.
    for (int n = 0; n < 16 && !(((k / 4) % 4) == 2 && (k % 4) == 2); n++) tick();
    chk("pre_rst_sel", digit_sel, 32'b1011);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", digit_sel, 32'b1110);
    chk("midrst_count", count, 32'h0000);
    chk("midrst_bcd", bcd, 0);
    chk("midrst_blank", blank, 0);
    tick();
    chk("midrst_carry", carry, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
